// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: d = x - y - b_in, one bit per clock, LSB first,
// through one full-adder cell (x + ~y + ~b_in) with carry feedback.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out,
  output logic             v,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic             carry_q, carry_d;
  logic             c_msb_q, c_msb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             b_out_q, b_out_d;
  logic             v_q, v_d;

  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] r_next;

  // The single full-adder cell shared by every bit position.
  assign sum_bit    = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign carry_next = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
  assign r_next     = {sum_bit, r_sr_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      carry_q <= 1'b0;
      c_msb_q <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      b_out_q <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      r_sr_q  <= r_sr_d;
      carry_q <= carry_d;
      c_msb_q <= c_msb_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      b_out_q <= b_out_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    r_sr_d  = r_sr_q;
    carry_d = carry_q;
    c_msb_d = c_msb_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    b_out_d = b_out_q;
    v_d     = v_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          // Subtraction as addition of the inverted subtrahend with inverted borrow-in as carry-in.
          a_sr_d  = x;
          b_sr_d  = ~y;
          carry_d = ~b_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        r_sr_d  = r_next;
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = carry_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_MSB) c_msb_d = carry_next;
        if (cnt_q == CNT_LAST) begin
          d_d     = r_next;
          b_out_d = ~carry_next;
          v_d     = c_msb_q ^ carry_next;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign d         = d_q;
  assign b_out     = b_out_q;
  assign v         = v_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed and random operations, expected results queued at
// issue time and checked by an independent monitor on every done pulse.
module tb_serial_subtractor;

  localparam int W  = 4;
  localparam int EW = W + 2;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         b_out;
  logic         v;
  logic [1:0]   state_dbg;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int busy_run = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .b_in(b_in),
    .busy(busy), .done(done), .d(d), .b_out(b_out), .v(v), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic, result packed as {d, b_out, v}.
  function automatic logic [EW-1:0] model(input logic [W-1:0] xa, input logic [W-1:0] ya,
                                          input logic ba);
    int ud, sd;
    logic [W-1:0] dd;
    logic bo, ov;
    ud = int'(xa) - int'(ya) - int'(ba);
    sd = int'($signed(xa)) - int'($signed(ya)) - int'(ba);
    dd = W'(ud);
    bo = (ud < 0);
    ov = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
    return {dd, bo, ov};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Driver: present operands at negedge, keep start for the accepting edge.
  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] ya, input logic ba,
                       input logic [EW-1:0] req, input bit hold);
    @(negedge clk);
    x = xa; y = ya; b_in = ba; start = 1'b1;
    exp_q.push_back(req);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || done) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++;
      $display("FAIL %s timeout: %0d results still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got d=0x%0h b_out=%0b v=%0b, expected no result", d, b_out, v);
      end else begin
        check("result", {d, b_out, v}, exp_q.pop_front());
        check("busy_cycles", EW'(busy_run), EW'(W));
      end
      busy_run = 0;
    end
  end

  typedef struct packed {
    logic [W-1:0] xa;
    logic [W-1:0] ya;
    logic         ba;
    logic [W-1:0] dd;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [W-1:0] rx, ry;
    logic         rb;
    // Hand-computed vectors (WIDTH=4).
    vecs[0] = '{4'h5, 4'h3, 1'b0, 4'h2, 1'b0, 1'b0};
    vecs[1] = '{4'h3, 4'h5, 1'b0, 4'hE, 1'b1, 1'b0};
    vecs[2] = '{4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1};
    vecs[3] = '{4'h7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1};
    vecs[4] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[5] = '{4'h0, 4'h8, 1'b0, 4'h8, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; x = '0; y = '0; b_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {d, b_out, v}, '0);
    check("reset_busy_done", EW'({busy, done}), '0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].xa, vecs[i].ya, vecs[i].ba, {vecs[i].dd, vecs[i].bo, vecs[i].ov}, 1'b0);
      wait_drain("directed");
    end

    // Back-to-back: start held, second operands applied right after acceptance.
    issue(4'h0, 4'h0, 1'b1, {4'hF, 1'b1, 1'b0}, 1'b1);
    x = 4'h9; y = 4'h4; b_in = 1'b1;
    exp_q.push_back({4'h4, 1'b0, 1'b1});
    begin
      int n;
      n = 0;
      while (!done && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) begin
        checks++;
        $display("FAIL b2b_first_done timeout: no done, expected done");
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain("back_to_back");

    // start pulsed mid-SHIFT must be ignored.
    issue(4'h5, 4'h3, 1'b0, {4'h2, 1'b0, 1'b0}, 1'b0);
    @(negedge clk);
    x = 4'h1; y = 4'h7; b_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("start_mid_shift");

    // Set a nonzero result, then reset mid-SHIFT: outputs clear at once, no done.
    issue(4'h7, 4'hF, 1'b0, {4'h8, 1'b1, 1'b1}, 1'b0);
    wait_drain("pre_reset");
    issue(4'h6, 4'h1, 1'b0, {4'h5, 1'b0, 1'b0}, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {d, b_out, v}, '0);
    check("rst_mid_busy_done", EW'({busy, done}), '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("no_done_after_abort", EW'(exp_q.size()), '0);

    issue(4'h3, 4'h5, 1'b0, {4'hE, 1'b1, 1'b0}, 1'b0);
    wait_drain("after_reset");

    for (int i = 0; i < 1000; i++) begin
      rx = W'($urandom_range(0, (1 << W) - 1));
      ry = W'($urandom_range(0, (1 << W) - 1));
      rb = 1'($urandom_range(0, 1));
      issue(rx, ry, rb, model(rx, ry, rb), 1'b0);
      wait_drain("random");
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
